// File: rtl/alu_mdu.sv
// Handshaked EX-stage ALU with iterative RV-M multiply/divide/remainder.
// Base ops retire one cycle after acceptance; M ops iterate one bit per cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluresult,
    output logic             less,
    output logic             zero,
    output logic             busy
);

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [SHW-1:0]     CNT_TOP  = SHW'(WIDTH-1);
    localparam logic [SHW-1:0]     CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0]     CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ZERO_W - v;
    endfunction

    state_t             state_r, state_s;
    logic [SHW-1:0]     cnt_r, cnt_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0]   opnd_r, opnd_s;
    logic [2:0]         func_r;
    logic               neg_r, rneg_r;
    logic               busy_r, out_valid_r, less_r, zero_r;
    logic [WIDTH-1:0]   res_r;

    logic               accept_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   base_res_s;
    logic               base_less_s, base_cmp_s, base_zero_s;
    logic               is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic               div_zero_s, div_ovf_s, fast_s;
    logic [WIDTH-1:0]   fast_res_s;
    logic [WIDTH-1:0]   mul_add_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s, div_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_res_s;

    assign in_ready  = (state_r == IDLE) & (~out_valid_r | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign aluresult = res_r;
    assign less      = less_r;
    assign zero      = zero_r;
    assign busy      = busy_r;
    assign shamt_s   = datab[SHW-1:0];

    // Single-cycle base ALU result and flags.
    always_comb begin
        base_res_s  = ZERO_W;
        base_less_s = 1'b0;
        base_cmp_s  = 1'b0;
        casez (op[3:0])
            4'b0000: base_res_s = dataa + datab;
            4'b1000: base_res_s = dataa - datab;
            4'b?001: base_res_s = dataa << shamt_s;
            4'b0010: begin
                base_cmp_s  = 1'b1;
                base_less_s = $signed(dataa) < $signed(datab);
                base_res_s  = {{(WIDTH-1){1'b0}}, base_less_s};
            end
            4'b1010: begin
                base_cmp_s  = 1'b1;
                base_less_s = dataa < datab;
                base_res_s  = {{(WIDTH-1){1'b0}}, base_less_s};
            end
            4'b?011: base_res_s = datab;
            4'b?100: base_res_s = dataa ^ datab;
            4'b0101: base_res_s = dataa >> shamt_s;
            4'b1101: base_res_s = $signed(dataa) >>> shamt_s;
            4'b?110: base_res_s = dataa | datab;
            4'b?111: base_res_s = dataa & datab;
            default: base_res_s = ZERO_W;
        endcase
        // Compares report operand equality rather than a zero result.
        base_zero_s = base_cmp_s ? (dataa == datab) : ~|base_res_s;
    end

    // M-op operand magnitudes, result signs and divide fast paths.
    always_comb begin
        is_div_s   = op[2];
        a_sgn_s    = is_div_s ? ~op[0] : ((op[1:0] == 2'b01) | (op[1:0] == 2'b10));
        b_sgn_s    = is_div_s ? ~op[0] : (op[1:0] == 2'b01);
        a_neg_s    = a_sgn_s & dataa[WIDTH-1];
        b_neg_s    = b_sgn_s & datab[WIDTH-1];
        a_mag_s    = a_neg_s ? neg_w(dataa) : dataa;
        b_mag_s    = b_neg_s ? neg_w(datab) : datab;
        div_zero_s = (datab == ZERO_W);
        div_ovf_s  = ~op[0] & (dataa == MIN_W) & (datab == ONES_W);
        fast_s     = is_div_s & (div_zero_s | div_ovf_s);
        if (div_zero_s) begin
            fast_res_s = op[1] ? dataa : ONES_W;
        end else if (div_ovf_s) begin
            fast_res_s = op[1] ? ZERO_W : dataa;
        end else begin
            fast_res_s = ZERO_W;
        end
    end

    // One shift-add step and one restoring-divide step over the shared accumulator.
    always_comb begin
        mul_add_s   = acc_r[0] ? opnd_r : ZERO_W;
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_add_s};
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        if (div_diff_s[WIDTH+1]) begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod_s = neg_r ? (ZERO_2W - acc_r) : acc_r;
        quo_s  = neg_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_s  = rneg_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        case (func_r)
            3'b000:                 fix_res_s = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res_s = quo_s;
            3'b110, 3'b111:         fix_res_s = rem_s;
            default:                fix_res_s = ZERO_W;
        endcase
    end

    // Next-state logic for the iterative sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        opnd_s  = opnd_r;
        case (state_r)
            IDLE: begin
                if (accept_s & op[4]) begin
                    if (fast_s) begin
                        state_s = DONE;
                    end else if (is_div_s) begin
                        state_s = DIV;
                        acc_s   = {ZERO_W, a_mag_s};
                        opnd_s  = b_mag_s;
                        cnt_s   = CNT_TOP;
                    end else begin
                        state_s = MUL;
                        acc_s   = {ZERO_W, b_mag_s};
                        opnd_s  = a_mag_s;
                        cnt_s   = CNT_TOP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                acc_s = mul_next_s;
                if (cnt_r == CNT_ZERO) begin
                    state_s = FIX;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            DIV: begin
                acc_s = div_next_s;
                if (cnt_r == CNT_ZERO) begin
                    state_s = FIX;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            FIX: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, datapath registers and captured operation attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            acc_r   <= ZERO_2W;
            opnd_r  <= ZERO_W;
            func_r  <= 3'b000;
            neg_r   <= 1'b0;
            rneg_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            opnd_r  <= opnd_s;
            busy_r  <= (state_s == MUL) | (state_s == DIV) | (state_s == FIX);
            if (accept_s & op[4]) begin
                func_r <= op[2:0];
                neg_r  <= a_neg_s ^ b_neg_s;
                rneg_r <= a_neg_s;
            end
        end
    end

    // Result registers: written on completion, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            res_r       <= ZERO_W;
            less_r      <= 1'b0;
            zero_r      <= 1'b0;
        end else if (accept_s & ~op[4]) begin
            out_valid_r <= 1'b1;
            res_r       <= base_res_s;
            less_r      <= base_less_s;
            zero_r      <= base_zero_s;
        end else if (accept_s & fast_s) begin
            out_valid_r <= 1'b1;
            res_r       <= fast_res_s;
            less_r      <= 1'b0;
            zero_r      <= ~|fast_res_s;
        end else if (state_r == FIX) begin
            out_valid_r <= 1'b1;
            res_r       <= fix_res_s;
            less_r      <= 1'b0;
            zero_r      <= ~|fix_res_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule
